mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and load/store share one memory port.
// One transaction in flight; round-robin on contention; response timeout with error pulse.
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  // fetch requester
  input  logic        if_valid,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  output logic        if_err,
  // load/store requester
  input  logic        ls_valid,
  input  logic        ls_write,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_ready,
  output logic        ls_rvalid,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  // memory side
  output logic        mem_valid,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_first;
  logic        r_last;
  logic        r_owner;
  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic [7:0]  r_cnt;
  logic        r_if_rvalid;
  logic        r_if_err;
  logic [63:0] r_if_rdata;
  logic        r_ls_rvalid;
  logic        r_ls_err;
  logic [63:0] r_ls_rdata;
  logic        w_grant_if;
  logic        w_grant_ls;
  logic        w_resp_ok;
  logic        w_timeout;

  // Grant decision; r_first keeps the cycle right after reset quiet.
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ls = 1'b0;
    if (r_state == S_IDLE && !r_first && !rst) begin
      if (if_valid && ls_valid) begin
        if (r_last == OWN_IF) begin
          w_grant_ls = 1'b1;
        end else begin
          w_grant_if = 1'b1;
        end
      end else if (if_valid) begin
        w_grant_if = 1'b1;
      end else if (ls_valid) begin
        w_grant_ls = 1'b1;
      end else begin
        w_grant_if = 1'b0;
      end
    end else begin
      w_grant_if = 1'b0;
    end
  end

  // A response beats a timeout if both land on the final wait cycle.
  always_comb begin
    w_resp_ok = (r_state == S_RESP) && mem_rvalid;
    w_timeout = (r_state == S_RESP) && !mem_rvalid && (r_cnt >= (TIMEOUT - 8'd1));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_if || w_grant_ls) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_RESP: begin
        if (w_resp_ok || w_timeout) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_first <= 1'b0;
    end
  end

  // Capture the winner's request; fetches always go out as plain reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= OWN_IF;
      r_owner <= OWN_IF;
      r_write <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_wmask <= 8'd0;
    end else if (w_grant_ls) begin
      r_last  <= OWN_LS;
      r_owner <= OWN_LS;
      r_write <= ls_write;
      r_addr  <= ls_addr;
      r_wdata <= ls_wdata;
      r_wmask <= ls_wmask;
    end else if (w_grant_if) begin
      r_last  <= OWN_IF;
      r_owner <= OWN_IF;
      r_write <= 1'b0;
      r_addr  <= if_addr;
      r_wdata <= 64'd0;
      r_wmask <= 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_REQ && mem_ready) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_RESP && r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // One-cycle response pulse to the owner; rdata holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= 64'd0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      r_ls_rdata  <= 64'd0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      if (w_resp_ok || w_timeout) begin
        if (r_owner == OWN_LS) begin
          r_ls_rvalid <= 1'b1;
          r_ls_err    <= w_timeout;
          r_ls_rdata  <= w_timeout ? 64'd0 : mem_rdata;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_err    <= w_timeout;
          r_if_rdata  <= w_timeout ? 64'd0 : mem_rdata;
        end
      end
    end
  end

  always_comb begin
    if_ready  = w_grant_if;
    ls_ready  = w_grant_ls;
    if_rvalid = !rst && r_if_rvalid;
    if_err    = !rst && r_if_err;
    if_rdata  = rst ? 64'd0 : r_if_rdata;
    ls_rvalid = !rst && r_ls_rvalid;
    ls_err    = !rst && r_ls_err;
    ls_rdata  = rst ? 64'd0 : r_ls_rdata;
    mem_valid = !rst && (r_state == S_REQ);
    mem_write = !rst && r_write;
    mem_addr  = rst ? 64'd0 : r_addr;
    mem_wdata = rst ? 64'd0 : r_wdata;
    mem_wmask = rst ? 8'd0 : r_wmask;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): table of transactions plus
// hand sequences for reset, reset mid-response and back-to-back grants.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, ls_valid, ls_write;
  logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_ready, mem_rvalid;
  logic        if_ready, if_rvalid, if_err, ls_ready, ls_rvalid, ls_err;
  logic [63:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic        mem_valid, mem_write;
  logic [7:0]  mem_wmask;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_valid(ls_valid), .ls_write(ls_write), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_ready(ls_ready),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifv;
    logic        lsv;
    logic        lsw;
    logic [63:0] ia;
    logic [63:0] la;
    logic [63:0] wd;
    logic [7:0]  wm;
    int          rdy_dly;
    int          rv_at;    // RESP cycle index of mem_rvalid, -1 = never (timeout)
    logic [63:0] mrd;
    logic        exp_ls;   // hand-computed winner
  } vec_t;

  vec_t rows[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".if_ready"}, {63'd0, if_ready}, 64'd0);
    chk({tag, ".ls_ready"}, {63'd0, ls_ready}, 64'd0);
    chk({tag, ".if_rvalid"}, {63'd0, if_rvalid}, 64'd0);
    chk({tag, ".ls_rvalid"}, {63'd0, ls_rvalid}, 64'd0);
    chk({tag, ".if_err"}, {63'd0, if_err}, 64'd0);
    chk({tag, ".ls_err"}, {63'd0, ls_err}, 64'd0);
    chk({tag, ".if_rdata"}, if_rdata, 64'd0);
    chk({tag, ".ls_rdata"}, ls_rdata, 64'd0);
    chk({tag, ".mem_valid"}, {63'd0, mem_valid}, 64'd0);
    chk({tag, ".mem_write"}, {63'd0, mem_write}, 64'd0);
    chk({tag, ".mem_addr"}, mem_addr, 64'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, ".mem_wmask"}, {56'd0, mem_wmask}, 64'd0);
  endtask

  task automatic run_row(input vec_t v, input int n);
    logic        e_w;
    logic [63:0] e_a, e_d, e_rd;
    logic [7:0]  e_m;
    int          pidx;
    string       t;
    t = $sformatf("row%0d", n);
    e_w = v.exp_ls ? v.lsw : 1'b0;
    e_a = v.exp_ls ? v.la : v.ia;
    e_d = v.exp_ls ? v.wd : 64'd0;
    e_m = v.exp_ls ? v.wm : 8'd0;
    e_rd = (v.rv_at < 0) ? 64'd0 : v.mrd;
    pidx = (v.rv_at < 0) ? TO : v.rv_at + 1;
    @(negedge clk);
    if_valid = v.ifv; ls_valid = v.lsv; if_addr = v.ia;
    ls_write = v.lsw; ls_addr = v.la; ls_wdata = v.wd; ls_wmask = v.wm;
    #1;
    chk({t, ".if_ready"}, {63'd0, if_ready}, {63'd0, !v.exp_ls});
    chk({t, ".ls_ready"}, {63'd0, ls_ready}, {63'd0, v.exp_ls});
    @(negedge clk);
    if_valid = 1'b0; ls_valid = 1'b0;
    for (int d = 0; d <= v.rdy_dly; d++) begin
      mem_ready = (d == v.rdy_dly);
      #1;
      chk({t, ".mem_valid"}, {63'd0, mem_valid}, 64'd1);
      chk({t, ".mem_write"}, {63'd0, mem_write}, {63'd0, e_w});
      chk({t, ".mem_addr"}, mem_addr, e_a);
      chk({t, ".mem_wdata"}, mem_wdata, e_d);
      chk({t, ".mem_wmask"}, {56'd0, mem_wmask}, {56'd0, e_m});
      @(negedge clk);
    end
    mem_ready = 1'b0;
    for (int i = 0; i <= pidx + 1; i++) begin
      mem_rvalid = (v.rv_at < 0) ? (i == TO) : (i == v.rv_at);
      mem_rdata  = mem_rvalid ? ((v.rv_at < 0) ? 64'hDEAD_DEAD_DEAD_DEAD : v.mrd) : 64'hBADB_ADBA_DBAD_BADB;
      #1;
      if (i == 0) chk({t, ".mem_valid_resp"}, {63'd0, mem_valid}, 64'd0);
      chk($sformatf("%s.own_rvalid@%0d", t, i), {63'd0, v.exp_ls ? ls_rvalid : if_rvalid}, {63'd0, i == pidx});
      chk($sformatf("%s.oth_rvalid@%0d", t, i), {63'd0, v.exp_ls ? if_rvalid : ls_rvalid}, 64'd0);
      if (i >= pidx) begin
        chk($sformatf("%s.rdata@%0d", t, i), v.exp_ls ? ls_rdata : if_rdata, e_rd);
        chk($sformatf("%s.err@%0d", t, i), {63'd0, v.exp_ls ? ls_err : if_err},
            {63'd0, (i == pidx) && (v.rv_at < 0)});
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    rows[0] = '{1'b1, 1'b1, 1'b0, 64'h8000_0100, 64'h8000_2000, 64'h0, 8'h00, 0, 0, 64'h0000_0000_DEAD_BEEF, 1'b1};
    rows[1] = '{1'b1, 1'b1, 1'b1, 64'h8000_0104, 64'h8000_2008, 64'hAAAA_5555_AAAA_5555, 8'hFF, 1, 1, 64'h0000_0013_0000_0013, 1'b0};
    rows[2] = '{1'b1, 1'b1, 1'b0, 64'h8000_0108, 64'h8000_2010, 64'h1234, 8'hAA, 0, 2, 64'h0123_4567_89AB_CDEF, 1'b1};
    rows[3] = '{1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 0, 1, 64'h0010_0073, 1'b0};
    rows[4] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'h0F, 3, 0, 64'h0, 1'b1};
    rows[5] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h8000_1008, 64'hFFFF_0000_FFFF_0000, 8'h00, 0, 3, 64'h55, 1'b1};
    rows[6] = '{1'b1, 1'b0, 1'b0, 64'h8000_0200, 64'h0, 64'h0, 8'h00, 0, -1, 64'h0, 1'b0};
    rows[7] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h8000_3000, 64'h0, 8'h00, 2, -1, 64'h0, 1'b1};
    rows[8] = '{1'b1, 1'b1, 1'b1, 64'h8000_020C, 64'h8000_3008, 64'h1, 8'h01, 0, 0, 64'h517, 1'b0};
    rows[9] = '{1'b1, 1'b0, 1'b0, 64'h8000_0300, 64'h0, 64'h0, 8'h00, 1, 2, 64'h7777, 1'b0};

    rst = 1'b1; if_valid = 1'b1; ls_valid = 1'b1; ls_write = 1'b0;
    if_addr = 64'h8000_0000; ls_addr = 64'h8000_1000; ls_wdata = 64'd0; ls_wmask = 8'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    repeat (2) @(negedge clk);
    #1 chk_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk_zero("post_reset");
    @(negedge clk);
    if_valid = 1'b0; ls_valid = 1'b0;

    for (int r = 0; r < 9; r++) run_row(rows[r], r);

    // Reset while waiting for a response: no pulse, stale response ignored.
    @(negedge clk);
    if_valid = 1'b1; if_addr = 64'h8000_0400;
    #1 chk("rr.if_ready", {63'd0, if_ready}, 64'd1);
    @(negedge clk);
    if_valid = 1'b0; mem_ready = 1'b1;
    #1 chk("rr.mem_valid", {63'd0, mem_valid}, 64'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFEED_FACE;
    #1 chk_zero("rst_in_resp");
    @(negedge clk);
    rst = 1'b0;
    #1 chk_zero("rst_in_resp_after");
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 chk("rr.late_if_rvalid", {63'd0, if_rvalid}, 64'd0);
    run_row(rows[9], 9);

    // Fetch response and load/store grant in the same cycle.
    @(negedge clk);
    if_valid = 1'b1; if_addr = 64'h8000_0500;
    #1 chk("b2b.if_ready", {63'd0, if_ready}, 64'd1);
    @(negedge clk);
    if_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_1111_2222;
    ls_valid = 1'b1; ls_write = 1'b0; ls_addr = 64'h8000_4000; ls_wdata = 64'd0; ls_wmask = 8'd0;
    #1 chk("b2b.ls_ready_busy", {63'd0, ls_ready}, 64'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("b2b.if_rvalid", {63'd0, if_rvalid}, 64'd1);
    chk("b2b.if_rdata", if_rdata, 64'h0000_0000_1111_2222);
    chk("b2b.ls_ready", {63'd0, ls_ready}, 64'd1);
    @(negedge clk);
    ls_valid = 1'b0; mem_ready = 1'b1;
    #1;
    chk("b2b.mem_valid", {63'd0, mem_valid}, 64'd1);
    chk("b2b.mem_addr", mem_addr, 64'h8000_4000);
    chk("b2b.if_rvalid_drop", {63'd0, if_rvalid}, 64'd0);
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h3333_4444_5555_6666;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("b2b.ls_rvalid", {63'd0, ls_rvalid}, 64'd1);
    chk("b2b.ls_rdata", ls_rdata, 64'h3333_4444_5555_6666);
    chk("b2b.ls_err", {63'd0, ls_err}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
